// File: rtl/led_matrix_pkg.sv
// Shared types and default geometry/timing for the LED matrix row scanner.
package led_matrix_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_t;

  localparam int DEF_ROWS         = 8;
  localparam int DEF_COLS         = 8;
  localparam int DEF_DWELL_CYCLES = 1000;
  localparam int DEF_BLANK_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/row_decoder.sv
// Binary row index to one-hot row drive; all rows off when disabled.
module row_decoder #(
  parameter int ROWS   = 8,
  parameter int RIDX_W = $clog2(ROWS)
) (
  input  logic              i_en,
  input  logic [RIDX_W-1:0] i_idx,
  output logic [ROWS-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int r = 0; r < ROWS; r++) begin
      o_onehot[r] = i_en && (i_idx == RIDX_W'(r));
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scans a per-frame snapshot of the board onto an LED matrix with blanking between rows.
//   state   | meaning
//   S_IDLE  | matrix dark, waiting for ena to start a frame
//   S_BLANK | all rows/cols off before the next row is driven
//   S_DRIVE | one row lit with its snapshot columns for the dwell time
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ena,
  input  logic [ROWS*COLS-1:0]     i_cells,
  output logic [ROWS-1:0]          o_rows,
  output logic [COLS-1:0]          o_cols,
  output logic [$clog2(ROWS)-1:0]  o_row_index,
  output logic                     o_frame_done
);

  localparam int RIDX_W = $clog2(ROWS);
  localparam int CNT_W  = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);

  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [RIDX_W-1:0] ROW_LAST   = RIDX_W'(ROWS - 1);

  if (ROWS < 2) begin : g_bad_rows
    $error("led_matrix_scanner: ROWS must be >= 2");
  end
  if (COLS < 1) begin : g_bad_cols
    $error("led_matrix_scanner: COLS must be >= 1");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("led_matrix_scanner: DWELL_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("led_matrix_scanner: BLANK_CYCLES must be >= 1");
  end

  scan_state_t            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [RIDX_W-1:0]      r_row;
  logic [ROWS*COLS-1:0]   r_snapshot;
  logic [ROWS-1:0]        r_rows;
  logic [COLS-1:0]        r_cols;
  logic                   r_frame_done;

  scan_state_t            w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [RIDX_W-1:0]      w_row_nxt;
  logic [ROWS*COLS-1:0]   w_snap_nxt;
  logic [ROWS-1:0]        w_rows_nxt;
  logic [COLS-1:0]        w_cols_nxt;
  logic                   w_done_nxt;
  logic                   w_blank_end;
  logic                   w_dwell_end;

  assign w_blank_end = (r_cnt == BLANK_LAST);
  assign w_dwell_end = (r_cnt == DWELL_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_snapshot   <= '0;
      r_rows       <= '0;
      r_cols       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_row        <= w_row_nxt;
      r_snapshot   <= w_snap_nxt;
      r_rows       <= w_rows_nxt;
      r_cols       <= w_cols_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_snap_nxt  = r_snapshot;
    case (r_state)
      S_IDLE: begin
        if (i_ena) begin
          w_state_nxt = S_BLANK;
          w_snap_nxt  = i_cells;
          w_row_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_BLANK: begin
        if (w_blank_end) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DRIVE: begin
        if (w_dwell_end) begin
          w_cnt_nxt = '0;
          if (r_row != ROW_LAST) begin
            w_row_nxt   = r_row + RIDX_W'(1);
            w_state_nxt = S_BLANK;
          end else begin
            // Frame boundary: the only place ena is consulted while scanning.
            w_row_nxt = '0;
            if (i_ena) begin
              w_snap_nxt  = i_cells;
              w_state_nxt = S_BLANK;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state.
  row_decoder #(
    .ROWS   (ROWS),
    .RIDX_W (RIDX_W)
  ) u_row_decoder (
    .i_en     (w_state_nxt == S_DRIVE),
    .i_idx    (w_row_nxt),
    .o_onehot (w_rows_nxt)
  );

  always_comb begin
    w_done_nxt = (r_state == S_DRIVE) && w_dwell_end && (r_row == ROW_LAST);
    w_cols_nxt = '0;
    if (w_state_nxt == S_DRIVE) begin
      for (int r = 0; r < ROWS; r++) begin
        if (w_row_nxt == RIDX_W'(r)) begin
          w_cols_nxt = r_snapshot[r*COLS +: COLS];
        end
      end
    end
  end

  assign o_rows       = r_rows;
  assign o_cols       = r_cols;
  assign o_row_index  = r_row;
  assign o_frame_done = r_frame_done;

endmodule
